display_value_scheduler: RTL and testbench
==========================================

Name: display_value_scheduler

Overview:
Arbitrates between NUM_REQ binary value sources (e.g. SSVEP detected frequency, ADS1299 channel sample) for ownership of the six-digit seven-segment display. It converts the granted value to six BCD digits with an iterative shift-add-3 (double-dabble) engine. It drives bcd0..bcd5 of BCD_display with registered digits that change atomically. It sits between the processing cores and BCD_display in the top level.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
W, 20, binary value width per requester (20..24)
MAX_VAL, 999999, largest displayable value; larger inputs saturate

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  request per source, level, held until ack
val  in  NUM_REQ*W  flattened values; source i at [i*W +: W], stable while req[i]=1
freeze  in  1  1 = no new grants; display holds
ack  out  NUM_REQ  one-cycle pulse: value of source i captured
busy  out  1  1 while a conversion is in progress (CONV or UPD)
done  out  1  one-cycle pulse: new digits on bcd outputs
src  out  2  index of source currently shown
ovf  out  1  1 = shown value was saturated
bcd0..bcd5  out  4 each  BCD digits, bcd0 = units, bcd5 = hundred-thousands

Behaviour:
- Reset (async, reset_n=0): state IDLE; ack, done, busy, ovf = 0; src = 0; bcd0..bcd5 = 0; RR pointer = 0; shift and BCD working registers = 0. Reset mid-conversion aborts with no done; the display shows 000000.
- FSM states: IDLE, CONV, UPD.
- IDLE:
  - If freeze=0 and any req bit is set, grant round-robin starting at the RR pointer.
  - On the grant edge: capture min(val_i, MAX_VAL) into the shift register; latch sat = (val_i > MAX_VAL); clear BCD working register; cnt = 0.
  - ack[i] is high in the following cycle. RR pointer = i+1 mod NUM_REQ. Next state CONV.
- CONV: each edge performs one double-dabble step:
  - add 3 to every working digit >= 5;
  - shift {bcd_work, shift_reg} left by 1;
  - cnt++.
  - After W steps (cnt==W-1 edge), next state UPD.
- UPD (one edge): load bcd0..bcd5 from the working register; src = granted index; ovf = sat; done high in the following cycle; next state IDLE.
- Latency: grant edge E0 → digits and done visible after edge E(W+1). Default 22 cycles from the cycle req is sampled. Earliest next grant is edge E(W+2).
- busy = 1 in CONV and UPD; 0 in IDLE.
- bcd outputs change only in UPD; they are never partially updated.
- freeze:
  - Sampled only in IDLE.
  - Asserting it during CONV does not abort; that conversion completes and displays.
  - Requests stay pending, with no ack, while freeze=1.
- A req dropped before ack is simply not granted. The val of the granted source is ignored after the grant edge.
- Simultaneous requests: the first set bit at or after the RR pointer (wrapping) wins; the others wait.
- With a single active requester, it is regranted every W+2 cycles.
- Saturation: clamp to MAX_VAL (999999 → all digits 9), ovf=1. W=20 covers 0..1048575, so only 999999 < v <= 1048575 saturates at default.

Decomposition:
- Package display_pkg:
  - NUM_DIGITS=6 and MAX_DISPLAY=999999;
  - state encoding IDLE/CONV/UPD;
  - 24-bit BCD word type (6×4 bits).
- Sub-module bin2bcd_iter:
  - start/busy/done handshake;
  - owns the shift register, cnt, and the add-3 step;
  - W parameter.
- Arbiter, saturation, and output registers stay in display_value_scheduler.

Test Plan:
- Reset → all bcd=0, ack/done/busy/ovf=0. Then req[0]=1, val0=123456 → ack[0] 1 cycle; done at cycle 22; bcd5..bcd0=1,2,3,4,5,6; src=0; ovf=0.
- val0=0, then val0=999999 → digits 000000, then 999999, ovf=0. val1=1048575 → 999999, ovf=1, src=1.
- req=2'b11 held, val0=111111, val1=222222 → grants alternate 0,1,0,1, each done 22 cycles apart. Display alternates 111111/222222. No ack overlaps busy.
- freeze=1 in IDLE with req[1]=1 → no ack, digits hold. freeze=1 mid-CONV → current done still occurs. freeze=0 → req[1] granted next cycle.
- reset_n low at cycle 10 of a conversion of 654321 → outputs immediately 0, no done. After release with req still high → fresh grant, done 22 cycles later, 654321.
- req[0] asserted for 1 cycle while busy, then dropped → never acked, display unchanged.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the six-digit BCD display path.
package display_pkg;

  localparam int unsigned NUM_DIGITS  = 6;
  localparam int unsigned MAX_DISPLAY = 999999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    UPD  = 2'd2
  } state_t;

  typedef logic [4*NUM_DIGITS-1:0] bcd_word_t;

  // Double-dabble correction: add 3 to every digit that is 5 or more.
  function automatic bcd_word_t bcd_adjust(input bcd_word_t w);
    bcd_word_t r;
    r = w;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (w[4*d +: 4] >= 4'd5) r[4*d +: 4] = w[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per clock.
// A start pulse while idle loads din; W steps later done pulses and bcd holds
// the result. last flags the cycle whose edge performs the final step.
module bin2bcd_iter
  import display_pkg::*;
#(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         last,
  output logic         done,
  output bcd_word_t    bcd
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  shreg;
  bcd_word_t     work;
  bcd_word_t     adj;
  logic [CW-1:0] cnt;

  // Digit correction applied before each shift.
  always_comb begin
    adj = bcd_adjust(work);
  end

  assign last = busy && (cnt == CW'(W - 1));
  assign bcd  = work;

  // Load on start, then shift {work, shreg} left once per cycle for W cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      work  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        shreg <= din;
        work  <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        work  <= {adj[4*NUM_DIGITS-2:0], shreg[W-1]};
        shreg <= {shreg[W-2:0], 1'b0};
        cnt   <= cnt + CW'(1);
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/display_value_scheduler.sv
// Round-robin arbiter that grants one value source at a time to the display,
// clamps the value to the displayable range, converts it to BCD and updates
// all six digit registers in a single cycle.
module display_value_scheduler
  import display_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned W       = 20,
  parameter int unsigned MAX_VAL = MAX_DISPLAY
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] val,
  input  logic                 freeze,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           src,
  output logic                 ovf,
  output logic [3:0]           bcd0,
  output logic [3:0]           bcd1,
  output logic [3:0]           bcd2,
  output logic [3:0]           bcd3,
  output logic [3:0]           bcd4,
  output logic [3:0]           bcd5
);

  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   ptr;
  logic [1:0]   sel;
  logic [1:0]   gnt;
  logic         found;
  logic         grant;
  logic         over;
  logic         sat;
  logic [W-1:0] sel_val;
  logic [W-1:0] clamp_val;
  logic         conv_busy;
  logic         conv_last;
  logic         conv_done;
  bcd_word_t    conv_bcd;

  // First requesting source at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(32'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = 2'((32'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // Selected value and its clamp to the displayable maximum.
  always_comb begin
    sel_val   = val[sel*W +: W];
    over      = (sel_val > MAX_W);
    clamp_val = over ? MAX_W : sel_val;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant)     state_nxt = CONV;
      CONV:    if (conv_last) state_nxt = UPD;
      UPD:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM-derived outputs and converter start.
  always_comb begin
    busy  = (state != IDLE);
    grant = (state == IDLE) && !freeze && found && !conv_busy;
  end

  bin2bcd_iter #(
    .W (W)
  ) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (grant),
    .din     (clamp_val),
    .busy    (conv_busy),
    .last    (conv_last),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Grant bookkeeping, ack pulse, and atomic display update in UPD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack  <= '0;
      done <= 1'b0;
      ptr  <= '0;
      gnt  <= '0;
      sat  <= 1'b0;
      src  <= '0;
      ovf  <= 1'b0;
      bcd0 <= '0;
      bcd1 <= '0;
      bcd2 <= '0;
      bcd3 <= '0;
      bcd4 <= '0;
      bcd5 <= '0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      if (grant) begin
        ack[sel] <= 1'b1;
        gnt      <= sel;
        sat      <= over;
        ptr      <= (32'(sel) >= NUM_REQ - 1) ? 2'd0 : sel + 2'd1;
      end
      if ((state == UPD) && conv_done) begin
        bcd0 <= conv_bcd[3:0];
        bcd1 <= conv_bcd[7:4];
        bcd2 <= conv_bcd[11:8];
        bcd3 <= conv_bcd[15:12];
        bcd4 <= conv_bcd[19:16];
        bcd5 <= conv_bcd[23:20];
        src  <= gnt;
        ovf  <= sat;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_value_scheduler.sv
// Randomized and directed bench for display_value_scheduler, checked every
// cycle against a countdown-based reference model of the scheduler.
module tb_display_value_scheduler;

  localparam int NUM_REQ = 2;
  localparam int W       = 20;
  localparam int MAXV    = 999999;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ*W-1:0] val = '0;
  logic                 freeze = 1'b0;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy, done, ovf;
  logic [1:0]           src;
  logic [3:0]           bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;

  always #5 clk = ~clk;

  display_value_scheduler #(
    .NUM_REQ (NUM_REQ),
    .W       (W),
    .MAX_VAL (MAXV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .val     (val),
    .freeze  (freeze),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .src     (src),
    .ovf     (ovf),
    .bcd0    (bcd0),
    .bcd1    (bcd1),
    .bcd2    (bcd2),
    .bcd3    (bcd3),
    .bcd4    (bcd4),
    .bcd5    (bcd5)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_drop = 1'b1;

  // Reference model: edges left until the display update, plus shown state.
  int                 m_left, m_rr, m_gnt, m_pend_val, m_disp, m_src;
  bit                 m_pend_sat, m_ovf, m_done;
  logic [NUM_REQ-1:0] m_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    int r, p;
    r = 0;
    p = 1;
    for (int d = 0; d < 6; d++) begin
      r = r | (((v / p) % 10) << (4 * d));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_left = 0; m_rr = 0; m_gnt = 0; m_pend_val = 0; m_pend_sat = 0;
    m_disp = 0; m_src = 0; m_ovf = 0; m_done = 0; m_ack = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    int w, v;
    bit hit;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_ack  = '0;
    m_done = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_disp = m_pend_val;
        m_ovf  = m_pend_sat;
        m_src  = m_gnt;
        m_done = 1;
      end
    end else if (!freeze && req != '0) begin
      hit = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!hit && req[(m_rr + k) % NUM_REQ]) begin
          hit = 1;
          w = (m_rr + k) % NUM_REQ;
        end
      end
      v          = int'(val[w*W +: W]);
      m_pend_sat = (v > MAXV);
      m_pend_val = m_pend_sat ? MAXV : v;
      m_gnt      = w;
      m_ack[w]   = 1'b1;
      m_rr       = (w + 1) % NUM_REQ;
      m_left     = W + 1;
    end
  endtask

  task automatic compare_all();
    check_eq("ack", 32'(ack), 32'(m_ack));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("busy", 32'(busy), 32'(m_left > 0));
    check_eq("src", 32'(src), 32'(m_src));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("digits", 32'({bcd5, bcd4, bcd3, bcd2, bcd1, bcd0}), 32'(to_bcd(m_disp)));
  endtask

  // One clock: model the edge, sample at the falling edge, release acked requests.
  task automatic tick();
    model_edge();
    @(negedge clk);
    compare_all();
    if (auto_drop) begin
      for (int i = 0; i < NUM_REQ; i++) if (m_ack[i]) req[i] = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic raise(input int i, input int v);
    val[i*W +: W] = W'(v);
    req[i] = 1'b1;
  endtask

  // Asynchronous reset asserted just after a falling edge, held two cycles.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    ticks(2);
    reset_n = 1'b1;
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return MAXV;
      2:       return 1048575;
      3:       return int'($urandom_range(999990, 1000010));
      default: return int'($urandom % 32'd1048576);
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // single conversion with 22-cycle latency
    raise(0, 123456);
    ticks(24);

    // range edges and saturation
    raise(0, 0);       ticks(24);
    raise(0, 999999);  ticks(24);
    raise(1, 1048575); ticks(24);

    // two held requesters alternate
    auto_drop = 1'b0;
    raise(0, 111111);
    raise(1, 222222);
    ticks(4 * 22 + 2);
    req = '0;
    ticks(24);
    auto_drop = 1'b1;

    // freeze in IDLE and during a conversion
    freeze = 1'b1;
    raise(1, 333333);
    ticks(10);
    freeze = 1'b0;
    ticks(5);
    freeze = 1'b1;
    raise(0, 444444);
    ticks(25);
    freeze = 1'b0;
    ticks(25);

    // reset in the middle of a conversion, request still held
    auto_drop = 1'b0;
    raise(0, 654321);
    ticks(10);
    do_reset();
    ticks(23);
    req = '0;
    ticks(24);
    auto_drop = 1'b1;

    // short pulse on req[0] while busy is never granted
    raise(1, 500000);
    ticks(3);
    raise(0, 777777);
    tick();
    req[0] = 1'b0;
    ticks(25);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && $urandom_range(0, 9) == 0) raise(i, rand_val());
        else if (req[i] && $urandom_range(0, 199) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) freeze = ~freeze;
      if ($urandom_range(0, 1999) == 0) do_reset();
      else tick();
    end
    req = '0;
    freeze = 1'b0;
    ticks(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
